// File: rtl/sr_lsu_pkg.sv
// Shared encodings for the load/store unit.
//   WBE_*    store size from the control decoder's byte-write enable
//   RVF3_*   funct3 load encodings
//   LSU_*    FSM state encodings
//   lsu_size_e / is_misaligned: access size and alignment check shared by RTL and bench
package sr_lsu_pkg;

    localparam logic [1:0] WBE_NO = 2'd0;
    localparam logic [1:0] WBE_B  = 2'd1;
    localparam logic [1:0] WBE_H  = 2'd2;
    localparam logic [1:0] WBE_W  = 2'd3;

    localparam logic [2:0] RVF3_LB  = 3'b000;
    localparam logic [2:0] RVF3_LH  = 3'b001;
    localparam logic [2:0] RVF3_LW  = 3'b010;
    localparam logic [2:0] RVF3_LBU = 3'b100;
    localparam logic [2:0] RVF3_LHU = 3'b101;

    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_REQ  = 2'd1;
    localparam logic [1:0] LSU_RSP  = 2'd2;
    localparam logic [1:0] LSU_DONE = 2'd3;

    typedef enum logic [1:0] {SizeB, SizeH, SizeW} lsu_size_e;

    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] lo);
        logic mis;
        case (size)
            SizeH:   mis = lo[0];
            SizeW:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/sr_lsu_if.sv
// Data-memory bus between the LSU (master) and memory (slave).
//   dmem_req_*  : request channel, valid/ready handshake with we/addr/be/wdata
//   dmem_rsp_*  : response channel, valid only (the master always accepts)
interface sr_lsu_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  dmem_req_valid;
    logic                  dmem_req_ready;
    logic                  dmem_we;
    logic [ADDR_W-1:0]     dmem_addr;
    logic [DATA_W/8-1:0]   dmem_be;
    logic [DATA_W-1:0]     dmem_wdata;
    logic                  dmem_rsp_valid;
    logic [DATA_W-1:0]     dmem_rsp_rdata;
    logic                  dmem_rsp_err;

    modport master (
        output dmem_req_valid, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata, dmem_rsp_err
    );

    modport slave (
        input  dmem_req_valid, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata, dmem_rsp_err
    );
endinterface

// File: rtl/sr_lsu_align.sv
// Combinational lane logic for the LSU.
//   size, zext, addr_lo : access size, zero-extend flag, byte offset within the word
//   wdata -> be, wdata_rep : byte strobes and lane-replicated store data
//   rdata -> rdata_ext     : selected byte/half of the read word, sign/zero-extended
module sr_lsu_align
    import sr_lsu_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        zext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign rd_half = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (size)
            SizeB: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{rd_byte[7] & ~zext}}, rd_byte};
            end
            SizeH: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{rd_half[15] & ~zext}}, rd_half};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/sr_lsu.sv
// Multi-cycle load/store unit between the control decoder and the data-memory bus.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   mem_read, write_byte_en, cmdF3   : decoder access type, store size, load size/sign
//   addr, wdata                      : ALU effective address, rs2 store data
//   stall                            : hold PC/regfile until the access completes
//   lsu_rdata, lsu_wb_en             : extended load result and its writeback enable
//   misaligned, access_fault         : one-cycle abort / bus-error pulses
//   dmem                             : data-memory bus (master side)
module sr_lsu
    import sr_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic [1:0]        write_byte_en,
    input  logic [2:0]        cmdF3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_wb_en,
    output logic              misaligned,
    output logic              access_fault,
    sr_lsu_if.master          dmem
);
    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W/8-1:0] be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                we_q, zext_q, err_q;
    lsu_size_e           size_q;

    logic      is_store, acc, idle, req_mis, start, rsp_take;
    lsu_size_e req_size, al_size;
    logic      req_zext, al_zext;
    logic [1:0] al_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_rdata;

    // A store wins over a simultaneous load request.
    assign is_store = (write_byte_en != WBE_NO);
    assign acc      = mem_read | is_store;
    assign idle     = (state_q == LSU_IDLE);

    always_comb begin
        req_size = SizeW;
        req_zext = 1'b0;
        if (is_store) begin
            case (write_byte_en)
                WBE_B:   req_size = SizeB;
                WBE_H:   req_size = SizeH;
                default: req_size = SizeW;
            endcase
        end else begin
            case (cmdF3)
                RVF3_LB:  req_size = SizeB;
                RVF3_LH:  req_size = SizeH;
                RVF3_LBU: begin req_size = SizeB; req_zext = 1'b1; end
                RVF3_LHU: begin req_size = SizeH; req_zext = 1'b1; end
                default:  req_size = SizeW;
            endcase
        end
    end

    assign req_mis  = acc & is_misaligned(req_size, addr[1:0]);
    assign start    = idle & acc & ~req_mis;
    assign rsp_take = (state_q == LSU_RSP) & dmem.dmem_rsp_valid;

    // One lane unit: fed from live inputs in IDLE (to build the request),
    // from the latched request afterwards (to extract the load data).
    assign al_size = idle ? req_size  : size_q;
    assign al_zext = idle ? req_zext  : zext_q;
    assign al_lo   = idle ? addr[1:0] : addr_q[1:0];

    sr_lsu_align u_align (
        .size      (al_size),
        .zext      (al_zext),
        .addr_lo   (al_lo),
        .wdata     (wdata),
        .rdata     (dmem.dmem_rsp_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (start) state_d = LSU_REQ;
            LSU_REQ:  if (dmem.dmem_req_ready) state_d = LSU_RSP;
            LSU_RSP:  if (dmem.dmem_rsp_valid) state_d = LSU_DONE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            zext_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SizeW;
        end else begin
            state_q <= state_d;
            if (start) begin
                addr_q  <= addr;
                be_q    <= al_be;
                wdata_q <= al_wdata;
                we_q    <= is_store;
                zext_q  <= req_zext;
                size_q  <= req_size;
                err_q   <= 1'b0;
            end
            if (rsp_take) begin
                err_q <= dmem.dmem_rsp_err;
                if (!we_q) rdata_q <= al_rdata;
            end
        end
    end

    assign stall        = start | (state_q == LSU_REQ) | (state_q == LSU_RSP);
    assign misaligned   = idle & req_mis;
    assign lsu_wb_en    = (state_q == LSU_DONE) & ~we_q & ~err_q;
    assign access_fault = (state_q == LSU_DONE) & err_q;
    assign lsu_rdata    = rdata_q;

    // Valid derives only from state, so an async reset drops it immediately.
    assign dmem.dmem_req_valid = (state_q == LSU_REQ);
    assign dmem.dmem_we        = we_q;
    assign dmem.dmem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
    assign dmem.dmem_be        = be_q;
    assign dmem.dmem_wdata     = wdata_q;
endmodule

// File: tb/tb_sr_lsu.sv
// Scoreboard bench for sr_lsu: stimulus pushes expected bus requests and
// completions; a negedge monitor pops and compares when the DUT presents them.
module tb_sr_lsu;
    import sr_lsu_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
    } req_t;

    typedef struct {
        logic        is_mis;
        logic        wb;
        logic [31:0] rdata;
        logic        fault;
        int          stall_cycles;
    } comp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic [1:0]  write_byte_en = 2'd0;
    logic [2:0]  cmdF3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall, lsu_wb_en, misaligned, access_fault;
    logic [31:0] lsu_rdata;

    int errors = 0;
    int checks = 0;
    req_t  req_q[$];
    comp_t comp_q[$];

    sr_lsu_if dmem_bus ();

    sr_lsu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read      (mem_read),
        .write_byte_en (write_byte_en),
        .cmdF3         (cmdF3),
        .addr          (addr),
        .wdata         (wdata),
        .stall         (stall),
        .lsu_rdata     (lsu_rdata),
        .lsu_wb_en     (lsu_wb_en),
        .misaligned    (misaligned),
        .access_fault  (access_fault),
        .dmem          (dmem_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected", name);
    endtask

    // Monitor: request handshakes, misaligned pulses and completions (stall falling).
    initial begin
        logic prev_stall = 1'b0;
        int   stall_cnt = 0;
        req_t  r;
        comp_t c;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                stall_cnt  = 0;
            end else begin
                if (dmem_bus.dmem_req_valid && dmem_bus.dmem_req_ready) begin
                    if (req_q.size() == 0) fail_evt("req_unexpected");
                    else begin
                        r = req_q.pop_front();
                        check("req_we", dmem_bus.dmem_we, r.we);
                        check("req_addr", dmem_bus.dmem_addr, r.addr);
                        check("req_be", dmem_bus.dmem_be, r.be);
                        if (r.chk_wdata) check("req_wdata", dmem_bus.dmem_wdata, r.wdata);
                    end
                end
                if (misaligned) begin
                    if (comp_q.size() == 0) fail_evt("mis_unexpected");
                    else begin
                        c = comp_q.pop_front();
                        check("mis_kind", 1'b1, c.is_mis);
                        check("mis_stall", stall, 1'b0);
                        check("mis_req_valid", dmem_bus.dmem_req_valid, 1'b0);
                    end
                end
                if (prev_stall && !stall) begin
                    if (comp_q.size() == 0) fail_evt("done_unexpected");
                    else begin
                        c = comp_q.pop_front();
                        check("done_kind", 1'b0, c.is_mis);
                        check("done_wb_en", lsu_wb_en, c.wb);
                        check("done_fault", access_fault, c.fault);
                        check("done_stall_cycles", stall_cnt, c.stall_cycles);
                        if (c.wb) check("done_rdata", lsu_rdata, c.rdata);
                    end
                end else if (lsu_wb_en || access_fault) begin
                    fail_evt("stray_wb_or_fault");
                end
                if (stall) stall_cnt++;
                else stall_cnt = 0;
                prev_stall = stall;
            end
        end
    end

    task automatic access(input logic rd, input logic [1:0] wbe, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int delay,
                          input logic [31:0] rsp_data, input logic err,
                          input req_t er, input comp_t ec);
        req_q.push_back(er);
        comp_q.push_back(ec);
        @(posedge clk); #1;
        mem_read = rd; write_byte_en = wbe; cmdF3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        // In REQ: scramble inputs, they must be ignored now.
        mem_read = 1'b0; write_byte_en = WBE_NO; addr = 32'hFFFF_FFFC; wdata = 32'h5A5A_5A5A;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("bp_stall", stall, 1'b1);
            check("bp_valid", dmem_bus.dmem_req_valid, 1'b1);
            check("bp_addr", dmem_bus.dmem_addr, er.addr);
            check("bp_be", dmem_bus.dmem_be, er.be);
            @(posedge clk); #1;
        end
        dmem_bus.dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_bus.dmem_req_ready = 1'b0;
        dmem_bus.dmem_rsp_valid = 1'b1;
        dmem_bus.dmem_rsp_rdata = rsp_data;
        dmem_bus.dmem_rsp_err   = err;
        @(posedge clk); #1;
        dmem_bus.dmem_rsp_valid = 1'b0;
        dmem_bus.dmem_rsp_err   = 1'b0;
    endtask

    task automatic misalign(input logic rd, input logic [1:0] wbe, input logic [2:0] f3,
                            input logic [31:0] a);
        comp_t c;
        c = '{1'b1, 1'b0, 32'h0, 1'b0, 0};
        comp_q.push_back(c);
        @(posedge clk); #1;
        mem_read = rd; write_byte_en = wbe; cmdF3 = f3; addr = a;
        @(posedge clk); #1;
        mem_read = 1'b0; write_byte_en = WBE_NO;
        @(negedge clk);
        check("mis_after_valid", dmem_bus.dmem_req_valid, 1'b0);
        check("mis_after_stall", stall, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dmem_bus.dmem_req_ready = 1'b0;
        dmem_bus.dmem_rsp_valid = 1'b0;
        dmem_bus.dmem_rsp_rdata = 32'h0;
        dmem_bus.dmem_rsp_err   = 1'b0;

        #12;
        check("rst_stall", stall, 1'b0);
        check("rst_req_valid", dmem_bus.dmem_req_valid, 1'b0);
        check("rst_wb_en", lsu_wb_en, 1'b0);
        check("rst_fault", access_fault, 1'b0);
        check("rst_rdata", lsu_rdata, 32'h0);
        check("rst_be", dmem_bus.dmem_be, 4'h0);
        check("rst_addr", dmem_bus.dmem_addr, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // SW
        access(1'b0, WBE_W, 3'b010, 32'h104, 32'hDEADBEEF, 0, 32'h0, 1'b0,
               '{1'b1, 32'h104, 4'b1111, 32'hDEADBEEF, 1'b1}, '{1'b0, 1'b0, 32'h0, 1'b0, 3});
        // SB at lane 3
        access(1'b0, WBE_B, 3'b000, 32'h103, 32'h000000A5, 0, 32'h0, 1'b0,
               '{1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5, 1'b1}, '{1'b0, 1'b0, 32'h0, 1'b0, 3});
        // SH at upper half
        access(1'b0, WBE_H, 3'b001, 32'h106, 32'h1234BEEF, 0, 32'h0, 1'b0,
               '{1'b1, 32'h104, 4'b1100, 32'hBEEFBEEF, 1'b1}, '{1'b0, 1'b0, 32'h0, 1'b0, 3});
        // LB / LBU at lane 2 of 0x1280FF34
        access(1'b1, WBE_NO, RVF3_LB, 32'h102, 32'h0, 0, 32'h1280FF34, 1'b0,
               '{1'b0, 32'h100, 4'b0100, 32'h0, 1'b0}, '{1'b0, 1'b1, 32'hFFFFFF80, 1'b0, 3});
        access(1'b1, WBE_NO, RVF3_LBU, 32'h102, 32'h0, 0, 32'h1280FF34, 1'b0,
               '{1'b0, 32'h100, 4'b0100, 32'h0, 1'b0}, '{1'b0, 1'b1, 32'h00000080, 1'b0, 3});
        // Misaligned: LH odd, LW half-offset, SH odd, SW byte-offset
        misalign(1'b1, WBE_NO, RVF3_LH, 32'h101);
        misalign(1'b1, WBE_NO, RVF3_LW, 32'h102);
        misalign(1'b0, WBE_H, 3'b000, 32'h103);
        misalign(1'b0, WBE_W, 3'b000, 32'h101);
        // LHU / LH upper half of 0x80011234
        access(1'b1, WBE_NO, RVF3_LHU, 32'h102, 32'h0, 0, 32'h80011234, 1'b0,
               '{1'b0, 32'h100, 4'b1100, 32'h0, 1'b0}, '{1'b0, 1'b1, 32'h00008001, 1'b0, 3});
        access(1'b1, WBE_NO, RVF3_LH, 32'h102, 32'h0, 0, 32'h80011234, 1'b0,
               '{1'b0, 32'h100, 4'b1100, 32'h0, 1'b0}, '{1'b0, 1'b1, 32'hFFFF8001, 1'b0, 3});
        // LW with 5 cycles of backpressure
        access(1'b1, WBE_NO, RVF3_LW, 32'h200, 32'h0, 5, 32'h12345678, 1'b0,
               '{1'b0, 32'h200, 4'b1111, 32'h0, 1'b0}, '{1'b0, 1'b1, 32'h12345678, 1'b0, 8});
        // Unlisted funct3 acts as LW
        access(1'b1, WBE_NO, 3'b011, 32'h020, 32'h0, 0, 32'h0BADBEEF, 1'b0,
               '{1'b0, 32'h020, 4'b1111, 32'h0, 1'b0}, '{1'b0, 1'b1, 32'h0BADBEEF, 1'b0, 3});
        // Load with bus error
        access(1'b1, WBE_NO, RVF3_LW, 32'h300, 32'h0, 0, 32'h11111111, 1'b1,
               '{1'b0, 32'h300, 4'b1111, 32'h0, 1'b0}, '{1'b0, 1'b0, 32'h0, 1'b1, 3});

        // Reset while in REQ
        @(posedge clk); #1;
        mem_read = 1'b1; cmdF3 = RVF3_LW; addr = 32'h40;
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", dmem_bus.dmem_req_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", dmem_bus.dmem_req_valid, 1'b0);
        check("async_rst_stall", stall, 1'b0);
        check("async_rst_rdata", lsu_rdata, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Late response after reset must be ignored
        dmem_bus.dmem_rsp_valid = 1'b1;
        dmem_bus.dmem_rsp_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_bus.dmem_rsp_valid = 1'b0;
        @(negedge clk);
        check("late_rsp_stall", stall, 1'b0);
        check("late_rsp_wb_en", lsu_wb_en, 1'b0);
        check("late_rsp_rdata", lsu_rdata, 32'h0);
        access(1'b1, WBE_NO, RVF3_LW, 32'h010, 32'h0, 0, 32'hCAFEF00D, 1'b0,
               '{1'b0, 32'h010, 4'b1111, 32'h0, 1'b0}, '{1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 3});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("req_queue_drained", req_q.size(), 0);
        check("comp_queue_drained", comp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
